// File: rtl/ysyx_23060208_axil_rd_master.sv
// ysyx_23060208_axil_rd_master: single-outstanding AXI-Lite read initiator for LSU loads with lane extract, extension and optional watchdog.
module ysyx_23060208_axil_rd_master #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [DATA_WIDTH-1:0] ld_addr,
  input  logic [1:0]            ld_size,
  input  logic                  ld_unsigned,
  output logic                  ld_rvalid,
  output logic [DATA_WIDTH-1:0] ld_rdata,
  output logic                  ld_err,
  output logic [DATA_WIDTH-1:0] m_araddr,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rvalid,
  output logic                  m_rready
);
`ifdef AXIL_RD_TIMEOUT_EN
  typedef enum logic [2:0] {IDLE, AR, R, RESP, DRAIN} state_t;
  logic [7:0] cnt_q, cnt_d;
  logic       to_q, to_d, ard_q, ard_d;
`else
  typedef enum logic [1:0] {IDLE, AR, R, RESP} state_t;
`endif
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d, rdata_q, rdata_d, ext;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d, err_q, err_d, misalign;
  logic [7:0]            lane_b;
  logic [15:0]           lane_h;
  assign misalign = (ld_size == 2'b11) | (ld_size == 2'b01 & ld_addr[0]) | (ld_size == 2'b10 & |ld_addr[1:0]);
  assign lane_b = 8'(m_rdata >> {addr_q[1:0], 3'b000});
  assign lane_h = 16'(m_rdata >> {addr_q[1], 4'b0000});
  assign ext = size_q == 2'b00 ? {{24{~uns_q & lane_b[7]}}, lane_b}
             : size_q == 2'b01 ? {{16{~uns_q & lane_h[15]}}, lane_h} : m_rdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef AXIL_RD_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
      ard_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef AXIL_RD_TIMEOUT_EN
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      ard_q   <= ard_d;
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef AXIL_RD_TIMEOUT_EN
    cnt_d   = (state_q == AR || state_q == R) ? cnt_q + 8'd1 : cnt_q;
    to_d    = to_q;
    ard_d   = ard_q | (m_arvalid & m_arready);
`endif
    case (state_q)
      IDLE: if (ld_valid) begin
        addr_d = ld_addr;
        size_d = ld_size;
        uns_d  = ld_unsigned;
        if (misalign) begin
          state_d = RESP;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          state_d = AR;
`ifdef AXIL_RD_TIMEOUT_EN
          cnt_d   = '0;
          ard_d   = 1'b0;
`endif
        end
      end
      AR: if (m_arready) state_d = R;
      R: if (m_rvalid) begin
        state_d = RESP;
        rdata_d = |m_rresp ? '0 : ext;
        err_d   = |m_rresp;
      end
`ifdef AXIL_RD_TIMEOUT_EN
      RESP: state_d = to_q ? DRAIN : IDLE;
      DRAIN: if (ard_q & m_rvalid) begin
        state_d = IDLE;
        to_d    = 1'b0;
      end
`else
      RESP: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
`ifdef AXIL_RD_TIMEOUT_EN
    if ((state_q == AR || state_q == R) && cnt_q == 8'(TIMEOUT_CYCLES - 1) && !(state_q == R && m_rvalid)) begin
      state_d = RESP;
      rdata_d = '0;
      err_d   = 1'b1;
      to_d    = 1'b1;
    end
`endif
  end
  always_comb begin
    ld_ready  = state_q == IDLE;
    ld_rvalid = state_q == RESP;
    ld_rdata  = rdata_q;
    ld_err    = err_q;
    m_araddr  = {addr_q[DATA_WIDTH-1:2], 2'b00};
`ifdef AXIL_RD_TIMEOUT_EN
    m_arvalid = state_q == AR || ((state_q == RESP || state_q == DRAIN) && to_q && !ard_q);
    m_rready  = state_q == R || (state_q == DRAIN && ard_q);
`else
    m_arvalid = state_q == AR;
    m_rready  = state_q == R;
`endif
  end
endmodule

// File: tb/tb_ysyx_23060208_axil_rd_master.sv
// tb_ysyx_23060208_axil_rd_master: directed self-checking bench for the AXI-Lite read initiator.
module tb_ysyx_23060208_axil_rd_master;
  logic        clk = 1'b0, rst = 1'b1;
  logic        ld_valid = 1'b0, ld_ready, ld_unsigned = 1'b0, ld_rvalid, ld_err;
  logic [31:0] ld_addr = '0, ld_rdata, m_araddr, m_rdata = '0;
  logic [1:0]  ld_size = '0, m_rresp = '0;
  logic        m_arvalid, m_arready = 1'b0, m_rvalid = 1'b0, m_rready;
  int          checks = 0, errors = 0;
  always #5 clk = ~clk;
  ysyx_23060208_axil_rd_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
    .ld_size(ld_size), .ld_unsigned(ld_unsigned), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .ld_err(ld_err), .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic load(input logic [31:0] a, input logic [1:0] sz, input logic u, input logic [31:0] d,
                      input logic [1:0] resp, input int arw, input int rw, input logic [31:0] exp_d, input logic exp_e);
    @(negedge clk);
    chk("ready_idle", ld_ready, 1);
    ld_valid = 1; ld_addr = a; ld_size = sz; ld_unsigned = u;
    @(negedge clk);
    ld_valid = 0;
    for (int i = 0; i < arw; i++) begin
      chk("arvalid_hold", m_arvalid, 1);
      chk("araddr_hold", m_araddr, {a[31:2], 2'b00});
      chk("rready_in_ar", m_rready, 0);
      @(negedge clk);
    end
    chk("arvalid", m_arvalid, 1);
    chk("araddr", m_araddr, {a[31:2], 2'b00});
    chk("ready_busy", ld_ready, 0);
    m_arready = 1;
    @(negedge clk);
    m_arready = 0;
    chk("arvalid_drop", m_arvalid, 0);
    for (int i = 0; i < rw; i++) begin
      chk("rready_wait", m_rready, 1);
      chk("rvalid_early", ld_rvalid, 0);
      @(negedge clk);
    end
    chk("rready", m_rready, 1);
    m_rvalid = 1; m_rdata = d; m_rresp = resp;
    @(negedge clk);
    m_rvalid = 0; m_rdata = 32'hDEADDEAD; m_rresp = 2'b00;
    chk("rvalid_pulse", ld_rvalid, 1);
    chk("rdata", ld_rdata, exp_d);
    chk("err", ld_err, exp_e);
    chk("rready_resp", m_rready, 0);
    @(negedge clk);
    chk("rvalid_single", ld_rvalid, 0);
    chk("ready_back", ld_ready, 1);
    chk("rdata_hold", ld_rdata, exp_d);
    chk("err_hold", ld_err, exp_e);
  endtask
  task automatic misal(input logic [31:0] a, input logic [1:0] sz);
    @(negedge clk);
    ld_valid = 1; ld_addr = a; ld_size = sz; ld_unsigned = 0;
    @(negedge clk);
    ld_valid = 0;
    chk("mis_rvalid", ld_rvalid, 1);
    chk("mis_err", ld_err, 1);
    chk("mis_rdata", ld_rdata, 0);
    chk("mis_arvalid", m_arvalid, 0);
    @(negedge clk);
    chk("mis_ready", ld_ready, 1);
    chk("mis_arvalid2", m_arvalid, 0);
    chk("mis_rvalid_off", ld_rvalid, 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", ld_ready, 1);
    chk("rst_arvalid", m_arvalid, 0);
    chk("rst_rready", m_rready, 0);
    chk("rst_rvalid", ld_rvalid, 0);
    chk("rst_err", ld_err, 0);
    chk("rst_rdata", ld_rdata, 0);
    chk("rst_araddr", m_araddr, 0);
    rst = 0;
    load(32'ha0000048, 2'b10, 0, 32'h00000001, 2'b00, 0, 0, 32'h00000001, 0);
    load(32'h80000003, 2'b00, 0, 32'h80000000, 2'b00, 0, 0, 32'hFFFFFF80, 0);
    load(32'h80000003, 2'b00, 1, 32'h80000000, 2'b00, 0, 0, 32'h00000080, 0);
    load(32'h80000002, 2'b01, 0, 32'hBEEF1234, 2'b00, 0, 0, 32'hFFFFBEEF, 0);
    load(32'h80000002, 2'b01, 1, 32'hBEEF1234, 2'b00, 0, 0, 32'h0000BEEF, 0);
    load(32'h80000001, 2'b00, 0, 32'h00007F80, 2'b00, 0, 0, 32'h0000007F, 0);
    load(32'h80000000, 2'b01, 0, 32'h00008001, 2'b00, 0, 0, 32'hFFFF8001, 0);
    load(32'h80000004, 2'b01, 1, 32'h00008001, 2'b00, 0, 0, 32'h00008001, 0);
    load(32'h80000010, 2'b10, 0, 32'h12345678, 2'b00, 5, 3, 32'h12345678, 0);
    load(32'h80000001, 2'b00, 0, 32'hFFFFFFFF, 2'b10, 0, 0, 32'h00000000, 1);
    load(32'h80000008, 2'b10, 0, 32'hCAFEF00D, 2'b00, 1, 1, 32'hCAFEF00D, 0);
    misal(32'h80000002, 2'b10);
    misal(32'h80000001, 2'b01);
    misal(32'h80000000, 2'b11);
    load(32'h80000020, 2'b10, 0, 32'h0BADBEEF, 2'b00, 0, 0, 32'h0BADBEEF, 0);
    @(negedge clk);
    ld_valid = 1; ld_addr = 32'h80000040; ld_size = 2'b10;
    @(negedge clk);
    ld_valid = 0;
    chk("mid_arvalid", m_arvalid, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("mid_ready", ld_ready, 1);
    chk("mid_arvalid_off", m_arvalid, 0);
    chk("mid_rdata", ld_rdata, 0);
`ifdef AXIL_RD_TIMEOUT_EN
    @(negedge clk);
    ld_valid = 1; ld_addr = 32'h02000000; ld_size = 2'b10;
    @(negedge clk);
    ld_valid = 0;
    m_arready = 1;
    @(negedge clk);
    m_arready = 0;
    chk("to_rready", m_rready, 1);
    repeat (14) @(negedge clk);
    chk("to_not_yet", ld_rvalid, 0);
    @(negedge clk);
    chk("to_rvalid", ld_rvalid, 1);
    chk("to_err", ld_err, 1);
    chk("to_rdata", ld_rdata, 0);
    chk("to_ready", ld_ready, 0);
    @(negedge clk);
    chk("drain_ready", ld_ready, 0);
    chk("drain_rready", m_rready, 1);
    chk("drain_arvalid", m_arvalid, 0);
    m_rvalid = 1; m_rdata = 32'h11111111;
    @(negedge clk);
    m_rvalid = 0;
    chk("drain_exit", ld_ready, 1);
    chk("drain_rvalid", ld_rvalid, 0);
    chk("drain_rdata", ld_rdata, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
